// File: rtl/aes_sbox_secondorder_tworegstages_final.sv
// ----------------------------------------------------------------------------
// aes_sbox_secondorder_tworegstages_final
//   Second-order masked AES forward S-box over three Boolean shares, with two
//   register stages (input -> stage-1 regs -> output regs).
//
//   Inversion is computed as x^254 = x^14 * (x^14)^8 * x^128 in GF(2^8).
//   Squaring is linear, so every power x^(2^k) is taken share-wise.
//     stage 1 : A = x^2 * x^4 * x^8, expanded into 27 cross-domain terms
//               x_i^2 * x_j^4 * x_k^8. Each term is refreshed and registered
//               uncompressed. The input shares are registered alongside.
//     stage 2 : compress A per domain, expand A * A^8 * x^128 into 27 terms,
//               refresh them, sum each domain, apply the affine map
//               share-wise, and register the result.
//   Refresh uses a ring of fresh bytes: term t gets r[t] ^ r[t+1 mod 27].
//   Each term sees two fresh bytes, and the whole ring cancels in the
//   recombined value.
//
// Ports
//   clk                     rising-edge clock
//   rst                     synchronous active-high reset, clears every register
//   rand_bit_cycle1[278:1]  fresh randomness for stage 1 (bits 216:1 used)
//   rand_bit_cycle2[508:1]  fresh randomness for stage 2 (bits 216:1 used)
//   sbox_input_share1..3    input shares
//   output_share1..3        registered output shares, 2-cycle latency
// ----------------------------------------------------------------------------

// Share-wise affine output map. The constant is added in a single domain only.
module aes_sbox_so_affine #(
   parameter bit ADD_C = 1'b0
) (
   input  logic [7:0] b_i,
   output logic [7:0] s_o
);
   always_comb begin
      s_o = b_i ^ {b_i[6:0], b_i[7]} ^ {b_i[5:0], b_i[7:6]}
                ^ {b_i[4:0], b_i[7:5]} ^ {b_i[3:0], b_i[7:4]};
      if (ADD_C) s_o = s_o ^ 8'h63;
   end
endmodule

module aes_sbox_secondorder_tworegstages_final (
   input  logic         clk,
   input  logic         rst,
   input  logic [278:1] rand_bit_cycle1,
   input  logic [508:1] rand_bit_cycle2,
   input  logic [7:0]   sbox_input_share1,
   input  logic [7:0]   sbox_input_share2,
   input  logic [7:0]   sbox_input_share3,
   output logic [7:0]   output_share1,
   output logic [7:0]   output_share2,
   output logic [7:0]   output_share3
);
   localparam int NS = 3;
   localparam int NT = NS * NS * NS;

   // GF(2^8) multiply, AES polynomial x^8+x^4+x^3+x+1
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int n = 0; n < 8; n++) begin
         if (b[n]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
      end
      return p;
   endfunction

   // a^(2^k): k repeated squarings, linear over shares
   function automatic logic [7:0] gf_pow2k(input logic [7:0] a, input int k);
      logic [7:0] r;
      r = a;
      for (int n = 0; n < k; n++) r = gf_mul(r, r);
      return r;
   endfunction

   // Ring refresh mask for term t: r[t] ^ r[t+1], wrapping at NT
   function automatic logic [7:0] ring_mask(input logic [8*NT-1:0] r, input int t);
      return r[8*t +: 8] ^ r[8*((t + 1) % NT) +: 8];
   endfunction

   logic [8*NT-1:0]    r1, r2;
   logic               unused_rand;
   logic [NS-1:0][7:0] x_d, x_q;      // input shares, carried into stage 2
   logic [NT-1:0][7:0] t1_d, t1_q;    // uncompressed, refreshed x^14 terms
   logic [NS-1:0][7:0] a_sh;          // compressed shares of x^14
   logic [NS-1:0][7:0] y_sh;          // shares of x^254
   logic [NS-1:0][7:0] out_d, out_q;

   assign r1          = rand_bit_cycle1[8*NT:1];
   assign r2          = rand_bit_cycle2[8*NT:1];
   assign unused_rand = ^{rand_bit_cycle1[278:8*NT+1], rand_bit_cycle2[508:8*NT+1]};
   assign x_d         = {sbox_input_share3, sbox_input_share2, sbox_input_share1};

   // Stage 1: term (i,j,k) = x_i^2 * x_j^4 * x_k^8, owned by domain i
   always_comb begin
      t1_d = '0;
      for (int i = 0; i < NS; i++)
         for (int j = 0; j < NS; j++)
            for (int k = 0; k < NS; k++)
               t1_d[9*i + 3*j + k] =
                  gf_mul(gf_mul(gf_pow2k(x_d[i], 1), gf_pow2k(x_d[j], 2)),
                         gf_pow2k(x_d[k], 3)) ^ ring_mask(r1, 9*i + 3*j + k);
   end

   // Stage 2: compress after the register, then term (i,k,l) =
   // A_i * A_k^8 * x_l^128, owned by domain i
   always_comb begin
      a_sh = '0;
      for (int i = 0; i < NS; i++)
         for (int m = 0; m < NS * NS; m++)
            a_sh[i] = a_sh[i] ^ t1_q[9*i + m];
   end

   always_comb begin
      y_sh = '0;
      for (int i = 0; i < NS; i++)
         for (int k = 0; k < NS; k++)
            for (int l = 0; l < NS; l++)
               y_sh[i] = y_sh[i]
                  ^ gf_mul(gf_mul(a_sh[i], gf_pow2k(a_sh[k], 3)), gf_pow2k(x_q[l], 7))
                  ^ ring_mask(r2, 9*i + 3*k + l);
   end

   for (genvar g = 0; g < NS; g++) begin : g_aff
      aes_sbox_so_affine #(.ADD_C(g == 0)) u_aff (
         .b_i (y_sh[g]),
         .s_o (out_d[g])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x_q   <= '0;
         t1_q  <= '0;
         out_q <= '0;
      end else begin
         x_q   <= x_d;
         t1_q  <= t1_d;
         out_q <= out_d;
      end
   end

   assign output_share1 = out_q[0];
   assign output_share2 = out_q[1];
   assign output_share3 = out_q[2];
endmodule

// File: tb/tb_aes_sbox_secondorder_tworegstages_final.sv
// ----------------------------------------------------------------------------
// Directed bench for the second-order masked AES S-box. It compares the XOR of
// the three output shares against the FIPS-197 S-box table.
// ----------------------------------------------------------------------------
module tb_aes_sbox_secondorder_tworegstages_final;
   logic         clk = 1'b0;
   logic         rst;
   logic [278:1] r1;
   logic [508:1] r2;
   logic [7:0]   s1, s2, s3;
   logic [7:0]   o1, o2, o3;

   int nvec = 0;
   int nerr = 0;

   logic [7:0] SBOX [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };

   aes_sbox_secondorder_tworegstages_final dut (
      .clk               (clk),
      .rst               (rst),
      .rand_bit_cycle1   (r1),
      .rand_bit_cycle2   (r2),
      .sbox_input_share1 (s1),
      .sbox_input_share2 (s2),
      .sbox_input_share3 (s3),
      .output_share1     (o1),
      .output_share2     (o2),
      .output_share3     (o3)
   );

   always #5 clk = ~clk;

   // n rising edges, then settle 1 time unit past the edge
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic rand_buses();
      for (int b = 1; b <= 278; b++) r1[b] = 1'($urandom_range(1, 0));
      for (int b = 1; b <= 508; b++) r2[b] = 1'($urandom_range(1, 0));
   endtask

   // random three-way split of x
   task automatic drive_split(input logic [7:0] x);
      s1 = 8'($urandom);
      s2 = 8'($urandom);
      s3 = x ^ s1 ^ s2;
   endtask

   function automatic logic [7:0] rec();
      return o1 ^ o2 ^ o3;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      s1 = 8'h12; s2 = 8'h34; s3 = 8'h56;
      rand_buses();
      tick(2);
      nvec++; if (o1 !== 8'h00) begin nerr++; $display("FAIL reset_share1 got %02h want 00", o1); end
      nvec++; if (o2 !== 8'h00) begin nerr++; $display("FAIL reset_share2 got %02h want 00", o2); end
      nvec++; if (o3 !== 8'h00) begin nerr++; $display("FAIL reset_share3 got %02h want 00", o3); end
      rst = 1'b0;
   endtask

   task automatic test_sweep();
      rand_buses();   // held fixed for the whole sweep
      for (int x = 0; x < 256; x++) begin
         s1 = 8'h00; s2 = 8'h00; s3 = 8'(x);
         tick(4);
         nvec++;
         if (rec() !== SBOX[x]) begin
            nerr++;
            $display("FAIL sweep x=%02h got %02h want %02h", x, rec(), SBOX[x]);
         end
      end
   endtask

   task automatic test_splits();
      logic [7:0] first_s1;
      bit         varied;
      varied = 1'b0;
      first_s1 = 8'h00;
      for (int t = 0; t < 8; t++) begin
         drive_split(8'h53);
         rand_buses();
         tick(2);
         nvec++;
         if (rec() !== 8'hED) begin
            nerr++;
            $display("FAIL split trial=%0d got %02h want ed", t, rec());
         end
         if (t == 0) first_s1 = o1;
         else if (o1 !== first_s1) varied = 1'b1;
      end
      nvec++;
      if (!varied) begin
         nerr++;
         $display("FAIL split_share_variation share1 stuck at %02h want varying", first_s1);
      end
   endtask

   task automatic test_hold();
      drive_split(8'h53);
      rand_buses();
      for (int c = 0; c < 5; c++) begin
         tick(1);
         if (c >= 1) begin
            nvec++;
            if (rec() !== 8'hED) begin
               nerr++;
               $display("FAIL hold cycle=%0d got %02h want ed", c, rec());
            end
         end
      end
   endtask

   // input n sampled at edge n+1, visible after edge n+2
   task automatic test_back_to_back();
      for (int c = 0; c < 18; c++) begin
         if (c < 16) drive_split(8'(c));
         rand_buses();
         tick(1);
         if (c >= 1 && c <= 16) begin
            nvec++;
            if (rec() !== SBOX[c-1]) begin
               nerr++;
               $display("FAIL b2b in=%02h got %02h want %02h", c - 1, rec(), SBOX[c-1]);
            end
         end
      end
   endtask

   task automatic test_mid_reset();
      drive_split(8'h53);
      rand_buses();
      tick(2);                 // pipeline full of 0x53
      rst = 1'b1;              // data presented at this edge must be dropped
      drive_split(8'h53);
      tick(1);
      nvec++; if (o1 !== 8'h00) begin nerr++; $display("FAIL midrst_share1 got %02h want 00", o1); end
      nvec++; if (o2 !== 8'h00) begin nerr++; $display("FAIL midrst_share2 got %02h want 00", o2); end
      nvec++; if (o3 !== 8'h00) begin nerr++; $display("FAIL midrst_share3 got %02h want 00", o3); end
      rst = 1'b0;
      drive_split(8'h10);
      rand_buses();
      tick(1);
      nvec++;
      if (rec() === 8'hED) begin
         nerr++;
         $display("FAIL midrst_flush got %02h want anything but ed", rec());
      end
      drive_split(8'h77);
      rand_buses();
      tick(1);
      nvec++;
      if (rec() !== 8'hCA) begin
         nerr++;
         $display("FAIL midrst_first got %02h want ca", rec());
      end
   endtask

   task automatic test_rand_timing();
      drive_split(8'hAA);
      rand_buses();
      tick(1);
      // second cycle: only stage-2 randomness matters for this operation
      for (int b = 1; b <= 508; b++) r2[b] = 1'($urandom_range(1, 0));
      drive_split(8'h00);
      tick(1);
      nvec++;
      if (rec() !== 8'hAC) begin
         nerr++;
         $display("FAIL rand_timing got %02h want ac", rec());
      end
   endtask

   initial begin
      rst = 1'b1;
      s1 = '0; s2 = '0; s3 = '0;
      r1 = '0; r2 = '0;
      test_reset();
      test_sweep();
      test_splits();
      test_hold();
      test_back_to_back();
      test_mid_reset();
      test_rand_timing();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
